// File: rtl/lfsr_prbs_gen_if.sv
// Stream and control bundle for lfsr_prbs_gen: seed load, skip-ahead control,
// handshaked LFSR output and period/status reporting.
interface lfsr_prbs_gen_if #(
  parameter int WIDTH = 26,
  parameter int CNT_W = 32
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             skip_start;
  logic [CNT_W-1:0] skip_n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             bit_out;
  logic             busy;
  logic             done;
  logic             seed_hit;
  logic [CNT_W-1:0] period;

  modport master (
    output load, din, skip_start, skip_n, out_ready,
    input  out_valid, q, bit_out, busy, done, seed_hit, period
  );

  modport slave (
    input  load, din, skip_start, skip_n, out_ready,
    output out_valid, q, bit_out, busy, done, seed_hit, period
  );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// Galois LFSR/PRBS source with handshaked output, seed load, skip-ahead and period measurement.
// Optional runtime-writable feedback taps are enabled with `define LFSR_TAPS_RT_EN.
module lfsr_prbs_gen #(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] TAPS  = 26'h2000023,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               STEPS = 1,
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef LFSR_TAPS_RT_EN
  input  logic             taps_we,
  input  logic [WIDTH-1:0] taps_in,
`endif
  lfsr_prbs_gen_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SKIP = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  // STEPS single Galois steps chained combinationally; only the final state is exposed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] taps);
    logic [WIDTH-1:0] v;
    v = s;
    for (int i = 0; i < STEPS; i++) begin
      v = (v >> 1) ^ (v[0] ? taps : '0);
    end
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] adv_cnt_q, adv_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             seed_hit_q, seed_hit_d;

  logic [WIDTH-1:0] taps_cur;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] adv_val;
  logic             taps_wr;
  logic             do_adv;

`ifdef LFSR_TAPS_RT_EN
  logic [WIDTH-1:0] taps_q, taps_d;

  assign taps_cur = taps_q;
  assign taps_wr  = taps_we && (state_q == IDLE);

  always_comb begin
    taps_d = taps_q;
    if (taps_wr && !bus.load) begin
      taps_d = taps_in | MSB_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps_q <= TAPS;
    end else begin
      taps_q <= taps_d;
    end
  end
`else
  assign taps_cur = TAPS;
  assign taps_wr  = 1'b0;
`endif

  assign load_val = (bus.din != '0) ? bus.din : SEED;
  assign adv_val  = advance(q_q, taps_cur);

  // Priority per cycle: load, then taps write, then skip start, then beat / skip step.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    ref_d      = ref_q;
    rem_d      = rem_q;
    adv_cnt_d  = adv_cnt_q;
    period_d   = period_q;
    done_d     = 1'b0;
    seed_hit_d = 1'b0;
    do_adv     = 1'b0;

    if (bus.load) begin
      q_d       = load_val;
      ref_d     = load_val;
      adv_cnt_d = '0;
      period_d  = '0;
      state_d   = IDLE;
    end else if (taps_wr) begin
      ref_d     = q_q;
      adv_cnt_d = '0;
      period_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.skip_start) begin
            rem_d   = bus.skip_n;
            state_d = SKIP;
          end else if (out_valid_q && bus.out_ready) begin
            do_adv = 1'b1;
          end
        end
        SKIP: begin
          if (rem_q != '0) begin
            do_adv = 1'b1;
            rem_d  = rem_q - 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      endcase
    end

    // An all-zero state can only arise from bad taps; recover to SEED without counting it.
    if (do_adv) begin
      if (q_q == '0) begin
        q_d = SEED;
      end else begin
        q_d       = adv_val;
        adv_cnt_d = (adv_cnt_q == CNT_MAX) ? CNT_MAX : adv_cnt_q + 1'b1;
        if (adv_val == ref_q) begin
          seed_hit_d = 1'b1;
          if ((period_q == '0) && (adv_cnt_q != CNT_MAX)) begin
            period_d = adv_cnt_q + 1'b1;
          end
        end
      end
    end

    out_valid_d = (state_d == IDLE) && !bus.load;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= SEED;
      ref_q       <= SEED;
      rem_q       <= '0;
      adv_cnt_q   <= '0;
      period_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      seed_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      ref_q       <= ref_d;
      rem_q       <= rem_d;
      adv_cnt_q   <= adv_cnt_d;
      period_q    <= period_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      seed_hit_q  <= seed_hit_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.bit_out   = q_q[0];
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == SKIP);
  assign bus.done      = done_q;
  assign bus.seed_hit  = seed_hit_q;
  assign bus.period    = period_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen (WIDTH=4, x^4+x^3+1 Galois mask 4'hC, period 15).
// The reference model is a precomputed cycle table indexed by position relative to the seed.
module tb_lfsr_prbs_gen;

  localparam int             W      = 4;
  localparam int             CW     = 32;
  localparam logic [W-1:0]   TAPS_P = 4'hC;
  localparam logic [W-1:0]   SEED_P = 4'h1;
  localparam int             PER    = 15;

  logic clk = 1'b0;
  logic rst_n;

  lfsr_prbs_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();

`ifdef LFSR_TAPS_RT_EN
  logic         taps_we = 1'b0;
  logic [W-1:0] taps_in = '0;
`endif

  lfsr_prbs_gen #(
    .WIDTH(W),
    .TAPS (TAPS_P),
    .SEED (SEED_P),
    .STEPS(1),
    .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef LFSR_TAPS_RT_EN
    .taps_we(taps_we),
    .taps_in(taps_in),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int           checks  = 0;
  int           errors  = 0;
  int           hit_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] seq[PER];
  int           ref_idx;
  int           adv;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < PER; i++) if (seq[i] == v) r = i;
    return r;
  endfunction

  function automatic logic [W-1:0] model_q();
    return seq[(ref_idx + adv) % PER];
  endfunction

  function automatic int model_period();
    return (adv >= PER) ? PER : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic [W-1:0] d,
                               input logic ss, input logic [CW-1:0] sn);
    bus.load       = ld;
    bus.din        = d;
    bus.skip_start = ss;
    bus.skip_n     = sn;
    tick();
    bus.load       = 1'b0;
    bus.skip_start = 1'b0;
  endtask

  // Monitor: every handshake consumes one expected value; seed_hit pulses are counted.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'(bus.q), 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checkOutput("beat_q", 32'(bus.q), 32'(e));
        checkOutput("beat_bit_out", 32'(bus.bit_out), 32'(e[0]));
      end
    end
    if (rst_n && bus.seed_hit) hit_cnt++;
  end

  task automatic stream(input int n);
    int budget;
    int h0;
    int a0;
    h0 = hit_cnt;
    a0 = adv;
    for (int k = 0; k < n; k++) exp_q.push_back(seq[(ref_idx + adv + k) % PER]);
    budget = 0;
    while (exp_q.size() != 0 && budget < n * 10 + 20) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      budget++;
    end
    bus.out_ready = 1'b0;
    checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    adv += n;
    tick();
    checkOutput("stream_seed_hits", 32'(hit_cnt - h0), 32'((adv / PER) - (a0 / PER)));
    checkOutput("stream_period", bus.period, 32'(model_period()));
    checkOutput("stream_q_after", 32'(bus.q), 32'(model_q()));
  endtask

  task automatic do_skip(input int n);
    int cyc;
    int bad;
    int h0;
    int a0;
    logic got;
    h0  = hit_cnt;
    a0  = adv;
    cyc = 0;
    bad = 0;
    got = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, CW'(n));
    while (cyc < n + 20) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (!bus.busy || bus.out_valid) bad++;
      tick();
      cyc++;
    end
    adv += n;
    checkOutput("skip_done_seen", 32'(got), 32'd1);
    checkOutput("skip_latency", 32'(cyc), 32'(n + 1));
    checkOutput("skip_busy_window", 32'(bad), 32'd0);
    checkOutput("skip_q", 32'(bus.q), 32'(model_q()));
    checkOutput("skip_busy_end", 32'(bus.busy), 32'd0);
    checkOutput("skip_valid_end", 32'(bus.out_valid), 32'd1);
    tick();
    checkOutput("skip_done_pulse", 32'(bus.done), 32'd0);
    checkOutput("skip_seed_hits", 32'(hit_cnt - h0), 32'((adv / PER) - (a0 / PER)));
    checkOutput("skip_period", bus.period, 32'(model_period()));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] d;
    logic         seen_done;

    seq[0] = SEED_P;
    for (int i = 1; i < PER; i++) seq[i] = (seq[i-1] >> 1) ^ (seq[i-1][0] ? TAPS_P : '0);

    rst_n          = 1'b0;
    bus.load       = 1'b0;
    bus.din        = '0;
    bus.skip_start = 1'b0;
    bus.skip_n     = '0;
    bus.out_ready  = 1'b0;
    repeat (3) tick();
    checkOutput("rst_q", 32'(bus.q), 32'(SEED_P));
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_seed_hit", 32'(bus.seed_hit), 32'd0);
    checkOutput("rst_period", bus.period, 32'd0);

    rst_n = 1'b1;
    tick();
    ref_idx = 0;
    adv     = 0;
    checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("table_pos4", 32'(seq[4]), 32'hD);

    // Full cycle back to the seed, then hold with out_ready low.
    stream(PER);
    checkOutput("full_cycle_period", bus.period, 32'd15);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_q", 32'(bus.q), 32'(model_q()));
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
    end

    repeat (3) stream($urandom_range(3, 20));

    // Zero load substitutes SEED.
    applyStimulus(1'b1, '0, 1'b0, '0);
    ref_idx = idx_of(SEED_P);
    adv     = 0;
    checkOutput("load0_q", 32'(bus.q), 32'(SEED_P));
    checkOutput("load0_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("load0_period", bus.period, 32'd0);
    tick();
    checkOutput("load0_valid_next", 32'(bus.out_valid), 32'd1);

    d = W'($urandom_range(2, 15));
    applyStimulus(1'b1, d, 1'b0, '0);
    ref_idx = idx_of(d);
    adv     = 0;
    checkOutput("load_rand_q", 32'(bus.q), 32'(d));
    tick();
    stream(PER);

    // Skip-ahead from the seed.
    applyStimulus(1'b1, SEED_P, 1'b0, '0);
    ref_idx = 0;
    adv     = 0;
    tick();
    do_skip(5);
    checkOutput("skip5_q_const", 32'(bus.q), 32'hA);
    do_skip(0);
    repeat (3) do_skip($urandom_range(0, 40));

    // Load aborts a running skip without a done pulse.
    applyStimulus(1'b0, '0, 1'b1, CW'(10));
    tick();
    tick();
    d = W'($urandom_range(1, 15));
    applyStimulus(1'b1, d, 1'b0, '0);
    ref_idx = idx_of(d);
    adv     = 0;
    checkOutput("abort_q", 32'(bus.q), 32'(d));
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_period", bus.period, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) seen_done = 1'b1;
      tick();
    end
    checkOutput("abort_no_done", 32'(seen_done), 32'd0);
    checkOutput("abort_q_stable", 32'(bus.q), 32'(d));

    // Reset in the middle of a skip.
    applyStimulus(1'b0, '0, 1'b1, CW'(10));
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midskip_rst_q", 32'(bus.q), 32'(SEED_P));
    checkOutput("midskip_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midskip_rst_done", 32'(bus.done), 32'd0);
    checkOutput("midskip_rst_period", bus.period, 32'd0);
    rst_n = 1'b1;
    tick();
    ref_idx = 0;
    adv     = 0;
    checkOutput("midskip_rst_valid", 32'(bus.out_valid), 32'd1);
    stream(PER + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_gen.md
Name: lfsr_prbs_gen

Overview:
Parametrised Galois LFSR/PRBS generator with configurable width, feedback polynomial and seed. It supports handshaked stream output, safe seed load, and a multi-cycle skip-ahead FSM. It also measures the sequence period relative to the last loaded seed. It sits in the test and scrambling infrastructure as the general-purpose pseudo-random source.

Parameters:
WIDTH, 26, LFSR state width in bits (>=2).
TAPS, 26'h2000023, Galois feedback mask XORed into the shifted state when the output bit is 1; bit WIDTH-1 must be set.
SEED, 1, reset and zero-substitute state; nonzero, WIDTH bits.
STEPS, 1, LFSR advances applied per accepted beat or per skip cycle (1..8), unrolled combinationally.
CNT_W, 32, width of skip count and period counter.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
load  in  1  load din as new state and reference seed
din  in  WIDTH  load value
skip_start  in  1  start skip-ahead of skip_n steps
skip_n  in  CNT_W  number of skip cycles
out_valid  out  1  q is valid for consumption
out_ready  in  1  consumer accepts q
q  out  WIDTH  current LFSR state
bit_out  out  1  q[0]
busy  out  1  skip in progress
done  out  1  one-cycle pulse, skip completed
seed_hit  out  1  one-cycle pulse, state returned to reference seed
period  out  CNT_W  advances between load/reset and first seed_hit; 0 until measured

Behaviour:
- Reset is on rst_n, synchronous, active-low; the clock is clk.
- Single step: nxt = (q >> 1) ^ (q[0] ? TAPS : 0). One advance = STEPS chained single steps.
- Reset values: q=SEED, ref=SEED, out_valid=0, busy=0, done=0, seed_hit=0, period=0, adv_cnt=0, state=IDLE.
- out_valid is registered. It goes to 1 the first cycle after reset deasserts and stays 1 while state=IDLE. It is 0 in SKIP and in the cycle a load takes effect.
- FSM states: IDLE, SKIP. Priority each cycle: load > skip_start > beat advance.
- load (any state): q <= (din != 0) ? din : SEED; ref <= same value; adv_cnt <= 0; period <= 0; state <= IDLE; busy <= 0. A load in SKIP aborts the skip with no done pulse.
- Beat: in IDLE, out_valid & out_ready & !load & !skip_start -> q <= advance(q); adv_cnt++.
- skip_start in IDLE with skip_n=N: rem <= N; state <= SKIP; busy <= 1. skip_start in SKIP is ignored.
- In SKIP, each cycle with rem != 0: q <= advance(q), rem--, adv_cnt++.
- In SKIP, the cycle rem == 0: state <= IDLE, busy <= 0, done <= 1 for one cycle, out_valid <= 1 the next cycle.
- N=0: one SKIP cycle, no advance, done pulse 2 cycles after skip_start.
- Lockup: if q == 0 at any advance point (only reachable via illegal TAPS), q <= SEED instead of advancing; adv_cnt is not incremented.
- seed_hit: pulses the cycle after an advance whose result equals ref. On the first hit after load/reset, period <= adv_cnt+1 (post-increment count) and holds until the next load/reset.
- adv_cnt saturates at all-ones. If it saturates, period stays 0.
- With STEPS>1, seed_hit compares only the final advanced state, not intermediate ones.

Optional Feature:
LFSR_TAPS_RT_EN
- Defined: adds ports taps_we (in, 1) and taps_in (in, WIDTH). A taps register resets to TAPS.
- taps_we in IDLE: taps <= taps_in | (1 << WIDTH-1), and resets adv_cnt/period as a load of the current q would (ref <= q). taps_we in SKIP is ignored.
- Not defined: ports absent; feedback fixed to parameter TAPS.

Test Plan:
- WIDTH=4, TAPS=4'b1100, SEED=1, STEPS=1; release reset, out_ready=1 -> q sequence 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1; seed_hit pulses once after 15 beats, period=15.
- load din=0 -> q=0001, ref=0001, out_valid=0 for that cycle, then 1; period=0.
- From q=0001, skip_start with skip_n=5 -> busy for 6 cycles, out_valid=0, done one pulse, q=1010 (A).
- skip_n=0 -> q unchanged, done pulse 2 cycles after start; load asserted mid-skip (skip_n=10, at cycle 3) -> skip aborted, no done, q=din.
- out_ready=0 for 5 cycles -> q held stable with out_valid=1; assert rst_n=0 mid-skip -> next cycle q=SEED, busy=0, done=0.
- LFSR_TAPS_RT_EN, WIDTH=4: taps_we with taps_in=4'b1001 -> taps=1001; from q=1, period measured as 15 (x^4+x+1 is primitive).
